// File: rtl/vxc_add_sequencer.sv
// Chunk sequencer for the conjugate vector-times-constant add/subtract datapath.
// Issues one chunk read per cycle and tracks each chunk to its write-back slot.
module vxc_add_sequencer #(
  parameter int NOE      = 19,
  parameter int NI       = 8,
  parameter int ADDR_W   = 8,
  parameter int ELEM_W   = 64,
  parameter int MEM_LAT  = 1,
  parameter int PIPE_LAT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_in,
  input  logic [ELEM_W-1:0] const_in,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dp_op,
  output logic [ELEM_W-1:0] dp_const,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NI-1:0]     wr_mask,
  output logic              busy,
  output logic              finish
);

  localparam int CHUNKS     = (NOE + NI - 1) / NI;
  localparam int LAST_LANES = NOE - (CHUNKS - 1) * NI;
  localparam int LAT        = MEM_LAT + PIPE_LAT;

  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(CHUNKS - 1);
  localparam logic [NI-1:0]     LAST_MASK = {NI{1'b1}} >> (NI - LAST_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                op_q, op_d;
  logic [ELEM_W-1:0]   const_q, const_d;
  logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
  logic [ADDR_W-1:0]   wr_base_q, wr_base_d;
  logic                finish_q, finish_d;
  logic [LAT-1:0]      pipe_v_q, pipe_v_d;
  logic [ADDR_W-1:0]   pipe_k_q [LAT];
  logic [ADDR_W-1:0]   pipe_k_d [LAT];
  logic                issue;
  logic                last_wr;

  // The oldest pipeline stage is the chunk whose result leaves the datapath now.
  assign last_wr = pipe_v_q[LAT-1] && (pipe_k_q[LAT-1] == LAST_K);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_d      = op_q;
    const_d   = const_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    finish_d  = finish_q;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op_in;
          const_d   = const_in;
          rd_base_d = rd_base;
          wr_base_d = wr_base;
          finish_d  = 1'b0;
          k_d       = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          if (k_q == LAST_K) state_d = DRAIN;
          else               k_d     = k_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (last_wr) begin
          finish_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Free-running shift: a hold bubble simply travels down as valid=0.
    pipe_v_d[0] = issue;
    pipe_k_d[0] = k_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_k_d[i] = pipe_k_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      op_q      <= 1'b0;
      const_q   <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      finish_q  <= 1'b0;
      pipe_v_q  <= '0;
      for (int i = 0; i < LAT; i++) pipe_k_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      op_q      <= op_d;
      const_q   <= const_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      finish_q  <= finish_d;
      pipe_v_q  <= pipe_v_d;
      for (int i = 0; i < LAT; i++) pipe_k_q[i] <= pipe_k_d[i];
    end
  end

  assign rd_en    = issue;
  assign rd_addr  = issue ? (rd_base_q + k_q) : '0;
  assign wr_en    = pipe_v_q[LAT-1];
  assign wr_addr  = pipe_v_q[LAT-1] ? (wr_base_q + pipe_k_q[LAT-1]) : '0;
  assign wr_mask  = !pipe_v_q[LAT-1] ? '0 : (last_wr ? LAST_MASK : {NI{1'b1}});
  assign dp_op    = op_q;
  assign dp_const = const_q;
  assign busy     = (state_q != IDLE);
  assign finish   = finish_q;

endmodule
